// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: aligns a halfword-granular fetch stream into 32-bit instructions, expanding RVC.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush, flush_pc             redirect request and target (bit0 ignored)
//   f_valid, f_ready, f_data    fetch word handshake, lowest halfword first
//   o_valid, o_ready            instruction handshake
//   o_instr, o_pc               expanded instruction and its PC
//   o_compressed, o_illegal     source was 16-bit / encoding unsupported
module rvc_fetch_aligner #(
    parameter int          FETCH_W  = 32,
    parameter int          BUF_HW   = 4,
    parameter bit          RVC_EN   = 1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    input  logic               f_valid,
    output logic               f_ready,
    input  logic [FETCH_W-1:0] f_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [31:0]        o_instr,
    output logic [31:0]        o_pc,
    output logic               o_compressed,
    output logic               o_illegal
);
    localparam int NH = FETCH_W / 16;
    localparam int PW = $clog2(BUF_HW);
    localparam int CW = $clog2(BUF_HW + 1);
    localparam int DW = (NH > 2) ? 2 : 1;

    logic [15:0]   r_buf [BUF_HW];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc;
    logic [DW-1:0] r_drop;
    logic          r_live;

    logic [15:0]   w_h0, w_h1;
    logic          w_16, w_pop, w_push, w_ill;
    logic [CW-1:0] w_pop_n, w_push_n, w_free;
    logic [31:0]   w_exp;
    logic [4:0]    w_rdp, w_rs1p, w_rd, w_rs2;
    logic [11:0]   w_imm6;
    logic [20:1]   w_j;
    logic [12:1]   w_b;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % BUF_HW);
    endfunction

    assign w_h0     = r_buf[r_head];
    assign w_h1     = r_buf[wrap(r_head, 1)];
    assign w_16     = w_h0[1:0] != 2'b11;
    // a 32-bit head needs both halves buffered before it is presented
    assign o_valid  = (r_count >= CW'(2)) || (r_count != '0 && w_16);
    assign w_pop    = o_valid && o_ready;
    assign w_pop_n  = w_pop ? (w_16 ? CW'(1) : CW'(2)) : '0;
    // space freed by a same-cycle pop counts towards accepting a word
    assign w_free   = CW'(BUF_HW) - r_count + w_pop_n;
    assign f_ready  = r_live && !flush && w_free >= CW'(NH);
    assign w_push   = f_valid && f_ready;
    assign w_push_n = w_push ? CW'(NH) - CW'(r_drop) : '0;

    assign w_rdp  = {2'b01, w_h0[4:2]};
    assign w_rs1p = {2'b01, w_h0[9:7]};
    assign w_rd   = w_h0[11:7];
    assign w_rs2  = w_h0[6:2];
    assign w_imm6 = {{6{w_h0[12]}}, w_h0[12], w_h0[6:2]};
    assign w_j    = {{9{w_h0[12]}}, w_h0[12], w_h0[8], w_h0[10:9], w_h0[6], w_h0[7], w_h0[2], w_h0[11], w_h0[5:3]};
    assign w_b    = {{4{w_h0[12]}}, w_h0[12], w_h0[6:5], w_h0[2], w_h0[11:10], w_h0[4:3]};

    always_comb begin
        w_ill = 1'b0;
        w_exp = {16'h0, w_h0};
        case ({w_h0[15:13], w_h0[1:0]})
            5'b000_00: if (w_h0[12:5] == 8'h0) w_ill = 1'b1;
                       else w_exp = {2'b00, w_h0[10:7], w_h0[12:11], w_h0[5], w_h0[6], 2'b00, 5'd2, 3'b000, w_rdp, 7'b0010011};
            5'b010_00: w_exp = {5'b0, w_h0[5], w_h0[12:10], w_h0[6], 2'b00, w_rs1p, 3'b010, w_rdp, 7'b0000011};
            5'b110_00: w_exp = {5'b0, w_h0[5], w_h0[12], w_rdp, w_rs1p, 3'b010, w_h0[11:10], w_h0[6], 2'b00, 7'b0100011};
            5'b000_01: w_exp = {w_imm6, w_rd, 3'b000, w_rd, 7'b0010011};
            5'b010_01: w_exp = {w_imm6, 5'd0, 3'b000, w_rd, 7'b0010011};
            5'b101_01: w_exp = {w_j[20], w_j[10:1], w_j[11], w_j[19:12], 5'd0, 7'b1101111};
            5'b110_01,
            5'b111_01: w_exp = {w_b[12], w_b[10:5], 5'd0, w_rs1p, 2'b00, w_h0[13], w_b[4:1], w_b[11], 7'b1100011};
            5'b010_10: if (w_rd == 5'd0) w_ill = 1'b1;
                       else w_exp = {4'b0, w_h0[3:2], w_h0[12], w_h0[6:4], 2'b00, 5'd2, 3'b010, w_rd, 7'b0000011};
            5'b110_10: w_exp = {4'b0, w_h0[8:7], w_h0[12], w_rs2, 5'd2, 3'b010, w_h0[11:9], 2'b00, 7'b0100011};
            5'b100_10: begin
                if (!w_h0[12]) begin
                    if (w_rs2 != 5'd0) w_exp = {7'd0, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
                    else if (w_rd != 5'd0) w_exp = {12'd0, w_rd, 3'b000, 5'd0, 7'b1100111};
                    else w_ill = 1'b1;
                end
                else if (w_rs2 != 5'd0) w_exp = {7'd0, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
                else w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign o_compressed = o_valid && w_16;
    assign o_illegal    = o_compressed && (!RVC_EN || w_ill);
    assign o_instr      = !o_valid ? 32'h0 : !w_16 ? {w_h1, w_h0} : (RVC_EN && !w_ill) ? w_exp : {16'h0, w_h0};
    assign o_pc         = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= RESET_PC;
            r_drop  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_pc    <= flush_pc & ~32'h1;
                // a mid-word target skips the leading halfwords of the next word
                r_drop  <= flush_pc[DW:1];
            end else begin
                r_head  <= wrap(r_head, int'(w_pop_n));
                r_tail  <= wrap(r_tail, int'(w_push_n));
                r_count <= r_count + w_push_n - w_pop_n;
                if (w_pop) r_pc <= r_pc + (w_16 ? 32'd2 : 32'd4);
                if (w_push) r_drop <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NH; j++)
            if (w_push && j >= int'(r_drop))
                r_buf[wrap(r_tail, j - int'(r_drop))] <= f_data[16*j +: 16];
    end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed bench for rvc_fetch_aligner with hand-computed expectations.
module tb_rvc_fetch_aligner;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        f_valid = 1'b0, o_ready = 1'b0;
    logic [31:0] f_data = 32'h0;
    logic        f_ready, o_valid, o_compressed, o_illegal;
    logic [31:0] o_instr, o_pc;
    logic        f_valid1 = 1'b0, o_ready1 = 1'b0;
    logic [31:0] f_data1 = 32'h0;
    logic        f_ready1, o_valid1, o_compressed1, o_illegal1;
    logic [31:0] o_instr1, o_pc1;
    int          n_cmp = 0, n_bad = 0;
    int          bi, bk;
    logic        acc, got;

    logic [15:0] tv_h [14] = '{16'h0040, 16'hC044, 16'hBFFD, 16'hC401, 16'h952E, 16'h4092, 16'h4002,
                               16'h9082, 16'h8082, 16'h852E, 16'h157D, 16'hFCFD, 16'hC406, 16'h0001};
    logic [31:0] tv_i [14] = '{32'h00410413, 32'h00942223, 32'hFFFFF06F, 32'h00040463, 32'h00B50533,
                               32'h00412083, 32'h0, 32'h0, 32'h00008067, 32'h00B00533, 32'hFFF50513,
                               32'hFE049FE3, 32'h00112423, 32'h00000013};
    logic        tv_ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rvc_fetch_aligner #(.FETCH_W(32), .BUF_HW(4), .RVC_EN(1), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_compressed(o_compressed), .o_illegal(o_illegal)
    );

    rvc_fetch_aligner #(.FETCH_W(32), .BUF_HW(4), .RVC_EN(0), .RESET_PC(32'h0)) u_dut_norvc (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .flush_pc(32'h0),
        .f_valid(f_valid1), .f_ready(f_ready1), .f_data(f_data1),
        .o_valid(o_valid1), .o_ready(o_ready1), .o_instr(o_instr1), .o_pc(o_pc1),
        .o_compressed(o_compressed1), .o_illegal(o_illegal1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] li_h(input int k);
        return 16'h4501 | 16'(k << 2);
    endfunction

    function automatic logic [31:0] li_i(input int k);
        return 32'(k << 20) | 32'h00000513;
    endfunction

    initial begin
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_fready", f_ready, 0);
        chk("rst_comp", o_compressed, 0);
        chk("rst_ill", o_illegal, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_pc", o_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_fready_lo", f_ready, 0);
        tick;
        chk("rel_fready_hi", f_ready, 1);

        o_ready = 1'b1;
        f_valid = 1'b1;
        f_data  = 32'h05134188;
        tick;
        chk("mix0_valid", o_valid, 1);
        chk("mix0_pc", o_pc, 32'h0);
        chk("mix0_instr", o_instr, 32'h0005A503);
        chk("mix0_comp", o_compressed, 1);
        f_data = 32'h00010010;
        #1;
        chk("mix_fready", f_ready, 1);
        tick;
        f_valid = 1'b0;
        chk("mix1_valid", o_valid, 1);
        chk("mix1_pc", o_pc, 32'h2);
        chk("mix1_instr", o_instr, 32'h00100513);
        chk("mix1_comp", o_compressed, 0);
        chk("mix1_ill", o_illegal, 0);
        tick;
        chk("mix2_pc", o_pc, 32'h6);
        chk("mix2_instr", o_instr, 32'h00000013);
        chk("mix2_comp", o_compressed, 1);
        tick;
        chk("mix_empty", o_valid, 0);
        chk("mix_pc_end", o_pc, 32'h8);

        o_ready = 1'b0;
        bi = 0;
        bk = 0;
        for (int c = 0; c < 80 && bk < 12; c++) begin
            if (c == 4) o_ready = 1'b1;
            f_valid = bi < 6;
            f_data  = {li_h(2 * bi + 1), li_h(2 * bi)};
            #1;
            if (c == 3) chk("bp_full", f_ready, 0);
            acc = f_valid && f_ready;
            got = o_valid && o_ready;
            if (got) begin
                chk("bp_instr", o_instr, li_i(bk));
                chk("bp_pc", o_pc, 32'h8 + 32'(2 * bk));
            end
            tick;
            if (acc) bi++;
            if (got) bk++;
        end
        f_valid = 1'b0;
        o_ready = 1'b0;
        chk("bp_count", bk, 12);
        chk("bp_words", bi, 6);

        flush    = 1'b1;
        flush_pc = 32'h00000102;
        tick;
        flush = 1'b0;
        chk("fl_valid", o_valid, 0);
        chk("fl_pc", o_pc, 32'h102);
        f_valid = 1'b1;
        f_data  = 32'h00010513;
        tick;
        f_valid = 1'b0;
        chk("fl_out_valid", o_valid, 1);
        chk("fl_out_pc", o_pc, 32'h102);
        chk("fl_out_instr", o_instr, 32'h00000013);
        chk("fl_out_comp", o_compressed, 1);
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
        chk("fl_dropped", o_valid, 0);
        chk("fl_pc_next", o_pc, 32'h104);

        flush    = 1'b1;
        flush_pc = 32'h00000201;
        tick;
        flush = 1'b0;
        chk("tv_base_pc", o_pc, 32'h200);
        for (int p = 0; p < 7; p++) begin
            f_valid = 1'b1;
            f_data  = {tv_h[2 * p + 1], tv_h[2 * p]};
            tick;
            f_valid = 1'b0;
            for (int q = 0; q < 2; q++) begin
                chk("tv_valid", o_valid, 1);
                chk("tv_ill", o_illegal, tv_ill[2 * p + q]);
                chk("tv_comp", o_compressed, 1);
                if (!tv_ill[2 * p + q]) chk("tv_instr", o_instr, tv_i[2 * p + q]);
                chk("tv_pc", o_pc, 32'h200 + 32'(4 * p + 2 * q));
                o_ready = 1'b1;
                tick;
                o_ready = 1'b0;
            end
        end
        chk("tv_empty", o_valid, 0);

        f_valid = 1'b1;
        f_data  = {li_h(1), li_h(0)};
        tick;
        chk("fpp_fill", o_valid, 1);
        o_ready  = 1'b1;
        f_data   = {li_h(3), li_h(2)};
        flush    = 1'b1;
        flush_pc = 32'h00000040;
        #1;
        chk("fpp_fready", f_ready, 0);
        tick;
        flush   = 1'b0;
        f_valid = 1'b0;
        chk("fpp_valid", o_valid, 0);
        chk("fpp_pc", o_pc, 32'h40);
        o_ready = 1'b0;
        tick;
        chk("fpp_still_empty", o_valid, 0);
        f_valid = 1'b1;
        f_data  = {li_h(5), li_h(4)};
        tick;
        f_valid = 1'b0;
        chk("fpp_next_instr", o_instr, li_i(4));
        chk("fpp_next_pc", o_pc, 32'h40);

        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_fready", f_ready, 0);
        chk("mrst_pc", o_pc, 32'h0);
        chk("mrst_instr", o_instr, 0);
        chk("mrst_ill", o_illegal, 0);
        chk("mrst_comp", o_compressed, 0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_lo", f_ready, 0);
        tick;
        chk("mrst_rel_hi", f_ready, 1);
        chk("mrst_discard", o_valid, 0);
        f_valid = 1'b1;
        f_data  = 32'h00000000;
        tick;
        f_valid = 1'b0;
        chk("zero0_valid", o_valid, 1);
        chk("zero0_ill", o_illegal, 1);
        chk("zero0_comp", o_compressed, 1);
        chk("zero0_instr", o_instr, 0);
        chk("zero0_pc", o_pc, 32'h0);
        o_ready = 1'b1;
        tick;
        chk("zero1_valid", o_valid, 1);
        chk("zero1_ill", o_illegal, 1);
        chk("zero1_instr", o_instr, 0);
        chk("zero1_pc", o_pc, 32'h2);
        tick;
        o_ready = 1'b0;
        chk("zero_empty", o_valid, 0);

        f_valid1 = 1'b1;
        f_data1  = 32'h00004188;
        tick;
        f_valid1 = 1'b0;
        chk("norvc0_valid", o_valid1, 1);
        chk("norvc0_ill", o_illegal1, 1);
        chk("norvc0_instr", o_instr1, 32'h00004188);
        chk("norvc0_pc", o_pc1, 32'h0);
        o_ready1 = 1'b1;
        tick;
        chk("norvc1_valid", o_valid1, 1);
        chk("norvc1_ill", o_illegal1, 1);
        chk("norvc1_instr", o_instr1, 32'h0);
        chk("norvc1_pc", o_pc1, 32'h2);
        tick;
        chk("norvc_empty", o_valid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rvc_fetch_aligner.md
RVC_FETCH_ALIGNER -- requirements
Module: rvc_fetch_aligner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports `clk` and `rst_n`.
REQ-002 Parameter FETCH_W, default 32, SHALL set fetch word width; legal values 32 or 64.
REQ-003 Parameter BUF_HW, default 4, SHALL set halfword buffer depth; minimum FETCH_W/16+1.
REQ-004 Parameter RVC_EN, default 1, SHALL enable compressed expansion; 0 treats compressed encodings as illegal.
REQ-005 Parameter RESET_PC, default 32'h0, SHALL set the PC after reset.
REQ-006 Ports SHALL be:
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `flush`  in  1  redirect request
- `flush_pc`  in  32  redirect target
- `f_valid`  in  1  fetch word valid
- `f_ready`  out  1  aligner can accept a word
- `f_data`  in  FETCH_W  fetch word, lowest halfword first in program order
- `o_valid`  out  1  instruction valid
- `o_ready`  in  1  consumer accepts
- `o_instr`  out  32  expanded 32-bit instruction
- `o_pc`  out  32  PC of `o_instr`
- `o_compressed`  out  1  source was 16-bit
- `o_illegal`  out  1  illegal or unsupported encoding

Function
REQ-007 Storage SHALL be a circular halfword FIFO of BUF_HW entries, with head/tail pointers wrapping modulo BUF_HW and an occupancy count.
REQ-008 `f_ready` SHALL be 1 when free entries ≥ FETCH_W/16 and `flush` = 0; the count includes entries freed by a same-cycle pop.
REQ-009 A push SHALL occur when `f_valid` & `f_ready`; all FETCH_W/16 halfwords are written, except as defined in REQ-014.
REQ-010 `o_valid` SHALL be 1 when either:
- count ≥ 1 and head[1:0] ≠ 2'b11; or
- count ≥ 2.

A 32-bit instruction whose upper half is not yet buffered SHALL hold `o_valid` at 0.
REQ-011 A pop on `o_valid` & `o_ready` SHALL remove 1 halfword for a compressed or illegal-16 head, and 2 halfwords otherwise. `o_pc` SHALL then advance by 2 or 4 respectively.
REQ-012 Outputs SHALL be combinational from the buffer head. Latency SHALL be 1 cycle from push to `o_valid`. A simultaneous push and pop SHALL both take effect.
REQ-013 Expansion SHALL cover the following; any other compressed encoding SHALL set `o_illegal`:
- C.ADDI4SPN, C.LW, C.SW
- C.NOP/C.ADDI, C.LI, C.J, C.BEQZ, C.BNEZ
- C.LWSP, C.SWSP, C.MV, C.ADD, C.JR
REQ-014 On `flush`:
- count SHALL clear and PC SHALL load `flush_pc` with bit0 forced to 0.
- Any same-cycle push or pop SHALL be discarded.
- If `flush_pc[1]`=1, the lowest halfword of the next accepted word SHALL be dropped; applies to FETCH_W=32 (for 64, bit1 selects among halfword offsets via `flush_pc[2:1]`).
REQ-015 A head halfword of 16'h0000 SHALL give `o_illegal`=1, `o_compressed`=1 and `o_instr`=32'h0, and SHALL pop 1 halfword.
REQ-016 With RVC_EN=0, any head with [1:0] ≠ 2'b11 SHALL give `o_illegal`=1 and `o_instr`={16'h0, head}, and SHALL pop 1 halfword.
REQ-017 For a 32-bit head, `o_instr` SHALL equal {head+1, head} unmodified. `o_illegal`=0 and `o_compressed`=0.
REQ-018 `o_instr`, `o_compressed` and `o_illegal` SHALL be don't-care while `o_valid`=0; the bench SHALL check them only when `o_valid`=1.

Reset
REQ-019 While `rst_n`=0, the following SHALL hold, independent of `clk`:
- count=0, pointers=0, PC=RESET_PC, drop-first flag=0
- `o_valid`=0, `f_ready`=0, `o_compressed`=0, `o_illegal`=0, `o_instr`=0, `o_pc`=RESET_PC

REQ-020 Reset asserted mid-operation SHALL discard all buffered halfwords. `f_ready` SHALL rise on the first clock edge after deassertion.

Verification
REQ-021 Mixed stream, FETCH_W=32, RESET_PC=0, `o_ready`=1; push 32'h05134188 then 32'h00010010. Required outputs, in order:
- pc 0x0: 32'h0005A503, compressed=1
- pc 0x2: 32'h00100513, compressed=0 (spans both words)
- pc 0x6: 32'h00000013, compressed=1
REQ-022 Backpressure: hold `o_ready`=0 and push continuously. `f_ready` SHALL drop once free entries < 2. No halfword SHALL be lost or duplicated after `o_ready` rises, including across pointer wrap.
REQ-023 Flush to 32'h00000102 with word 32'h00010513 pushed. The first output SHALL be pc 0x102, 32'h00000013; halfword 0x0513 SHALL be dropped.
REQ-024 Push 32'h00000000. Output SHALL be pc RESET_PC with `o_illegal`=1, then pc RESET_PC+2 with `o_illegal`=1.
REQ-025 Flush asserted in the same cycle as a push and a pop: the next cycle SHALL show count=0, `o_valid`=0 and PC=`flush_pc`.
REQ-026 With RVC_EN=0, push 32'h00004188. Output SHALL be `o_illegal`=1 with `o_instr`=32'h00004188 at pc 0, then a second illegal halfword at pc 2.
